// File: rtl/seq_right_shifter.sv
`default_nettype none
// ============================================================================
// Module   : seq_right_shifter
// Brief    : Multi-cycle logical/arithmetic right shifter, one bit per clock,
//            with start/busy/done handshake.
// Revision : 1.0
// ============================================================================
module seq_right_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               arith,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   data_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_acc;
    logic [SHAMT_W-1:0]   r_cnt;
    logic                 r_fill;
    logic [WIDTH-1:0]     r_data_out;
    logic [SHAMT_W-1:0]   w_cnt_init;

    // Counts beyond the word width would only repeat the fill bit.
    always_comb begin
        w_cnt_init = shamt;
        if (int'(shamt) >= WIDTH) begin
            w_cnt_init = SHAMT_W'(WIDTH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_fill     <= 1'b0;
            r_data_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc  <= data_in;
                        r_cnt  <= w_cnt_init;
                        r_fill <= arith & data_in[WIDTH-1];
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_acc <= {r_fill, r_acc[WIDTH-1:1]};
                        r_cnt <= r_cnt - SHAMT_W'(1);
                    end else begin
                        r_data_out <= r_acc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_seq_right_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_right_shifter
// Brief    : Self-checking bench: vector table, corner sequences, random ops.
// Revision : 1.0
// ============================================================================
module tb_seq_right_shifter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        arith = 1'b0;
    logic [5:0]  shamt6 = '0;
    logic [4:0]  shamt5;
    logic [31:0] data_in = '0;
    logic        busy5, done5, busy6, done6;
    logic [31:0] dout5, dout6;

    int n_checks = 0;
    int n_fail   = 0;

    assign shamt5 = shamt6[4:0];

    always #5 clk = ~clk;

    seq_right_shifter #(.WIDTH(32), .SHAMT_W(5)) u_dut (
        .clk(clk), .rst(rst), .start(start), .arith(arith), .shamt(shamt5),
        .data_in(data_in), .busy(busy5), .done(done5), .data_out(dout5)
    );

    // Wider count field so the clamp path is reachable.
    seq_right_shifter #(.WIDTH(32), .SHAMT_W(6)) u_dut6 (
        .clk(clk), .rst(rst), .start(start), .arith(arith), .shamt(shamt6),
        .data_in(data_in), .busy(busy6), .done(done6), .data_out(dout6)
    );

    typedef struct {
        logic [31:0] d;
        logic [5:0]  s;
        logic        a;
        logic [31:0] exp_out;
        int          exp_lat;
    } vec_t;

    function automatic logic [31:0] model(input logic [31:0] d, input int n, input logic a);
        int m;
        m = (n > 32) ? 32 : n;
        if (a) return 32'($signed(d) >>> m);
        return d >> m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Starts an op at the current negedge and follows it to completion.
    task automatic run_op(input logic [31:0] d, input logic [5:0] s, input logic a,
                          input bit use6, input bit scramble,
                          input logic [31:0] exp_out, input int exp_lat, input string name);
        int          k;
        bit          got;
        logic [31:0] prev, dout;
        logic        dn, bz;
        k = 0;
        while ((busy5 || busy6) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk({name, "_idle_timeout"}, 32'd1, 32'd0);
        prev    = use6 ? dout6 : dout5;
        start   = 1'b1;
        data_in = d;
        shamt6  = s;
        arith   = a;
        @(posedge clk);
        got = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (scramble) begin
                data_in = $urandom;
                shamt6  = 6'($urandom_range(0, 31));
                arith   = 1'($urandom_range(0, 1));
            end
            dn   = use6 ? done6 : done5;
            bz   = use6 ? busy6 : busy5;
            dout = use6 ? dout6 : dout5;
            if (dn) begin
                got = 1;
                chk({name, "_latency"}, 32'(c), 32'(exp_lat));
                chk({name, "_data_out"}, dout, exp_out);
                chk({name, "_busy_at_done"}, 32'(bz), 32'd1);
            end else begin
                if (bz !== 1'b1) chk({name, "_busy_during"}, 32'(bz), 32'd1);
                if (dout !== prev) chk({name, "_hold"}, dout, prev);
            end
        end
        if (!got) chk({name, "_done_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        chk({name, "_done_width"}, 32'(use6 ? done6 : done5), 32'd0);
        chk({name, "_busy_after"}, 32'(use6 ? busy6 : busy5), 32'd0);
    endtask

    initial begin
        vec_t        vt[7];
        int          n_done;
        logic [31:0] d;
        logic [5:0]  s;
        logic        a;
        bit          u6;

        vt[0] = '{32'h80000000, 6'd4,  1'b0, 32'h08000000, 6};
        vt[1] = '{32'h80000000, 6'd4,  1'b1, 32'hF8000000, 6};
        vt[2] = '{32'h80000001, 6'd31, 1'b1, 32'hFFFFFFFF, 33};
        vt[3] = '{32'h80000001, 6'd31, 1'b0, 32'h00000001, 33};
        vt[4] = '{32'h1234ABCD, 6'd0,  1'b1, 32'h1234ABCD, 2};
        vt[5] = '{32'h00FF0000, 6'd16, 1'b0, 32'h000000FF, 18};
        vt[6] = '{32'h87654321, 6'd1,  1'b1, 32'hC3B2A190, 3};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_data_out", dout5, 32'h0);
        chk("reset_busy", 32'(busy5), 32'd0);
        chk("reset_done", 32'(done5), 32'd0);
        chk("reset_data_out6", dout6, 32'h0);

        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].d, vt[i].s, vt[i].a, 1'b0, 1'b0, vt[i].exp_out, vt[i].exp_lat,
                   $sformatf("vec%0d", i));
        end

        // Clamp: counts at or above the word width give all-fill.
        run_op(32'h80000001, 6'd40, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 34, "clamp_sra");
        run_op(32'h80000001, 6'd63, 1'b0, 1'b1, 1'b0, 32'h00000000, 34, "clamp_srl");
        run_op(32'h7FFFFFFF, 6'd32, 1'b1, 1'b1, 1'b0, 32'h00000000, 34, "clamp_pos");

        // Starts while busy and during DONE must be ignored.
        start = 1'b1; data_in = 32'h0000F000; shamt6 = 6'd8; arith = 1'b0;
        @(posedge clk);
        n_done = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done5) n_done++;
            if (busy5) begin
                start = 1'b1; data_in = 32'hFFFFFFFF; shamt6 = 6'd1; arith = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done5) break;
        end
        @(negedge clk);
        chk("ignore_busy_after", 32'(busy5), 32'd0);
        chk("ignore_done_count", 32'(n_done), 32'd1);
        chk("ignore_data_out", dout5, 32'h000000F0);
        run_op(32'hAAAA0000, 6'd3, 1'b1, 1'b0, 1'b0, 32'hF5554000, 5, "after_ignore");

        // Reset in the middle of a shift discards it.
        start = 1'b1; data_in = 32'h12345678; shamt6 = 6'd20; arith = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy5), 32'd0);
        chk("midrst_done", 32'(done5), 32'd0);
        chk("midrst_data_out", dout5, 32'h0);
        n_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done5 || busy5) n_done++;
        end
        chk("midrst_no_done", 32'(n_done), 32'd0);
        run_op(32'h0F0F0F0F, 6'd4, 1'b0, 1'b0, 1'b0, 32'h00F0F0F0, 6, "after_rst");

        // Operands scrambled after accept.
        run_op(32'hFF000000, 6'd8, 1'b1, 1'b0, 1'b1, 32'hFFFF0000, 10, "scramble");

        for (int i = 0; i < 40; i++) begin
            d  = $urandom;
            s  = 6'($urandom_range(0, 40));
            a  = 1'($urandom_range(0, 1));
            u6 = (s >= 6'd32) ? 1'b1 : 1'($urandom_range(0, 1));
            run_op(d, s, a, u6, 1'($urandom_range(0, 1)), model(d, int'(s), a),
                   ((int'(s) > 32) ? 32 : int'(s)) + 2, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_right_shifter.md
Name: seq_right_shifter

Overview:
Multi-cycle right shifter that complements the existing combinational left shift datapath. It performs logical (SRL) and arithmetic (SRA) right shifts by shifting one bit position per clock. It sits beside the ALU for SRL/SRA/SRLV/SRAV, and a start/busy/done handshake lets the controller stall until the result is valid.

Parameters:
WIDTH, 32, data word width in bits.
SHAMT_W, 5, shift-amount field width in bits; must satisfy 2**SHAMT_W >= WIDTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request pulse; accepted only in IDLE.
arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); sampled on accept.
shamt  input  SHAMT_W  shift amount; sampled on accept.
data_in  input  WIDTH  operand; sampled on accept.
busy  output  1  high in SHIFT and DONE states.
done  output  1  one-cycle pulse, result valid.
data_out  output  WIDTH  result register; holds its value until the next completion.

Behaviour:
- Reset, on a clk edge with rst=1:
  - state=IDLE, acc=0, cnt=0, fill=0.
  - busy=0, done=0, data_out=0.
  - rst overrides everything, including an operation in progress; the partial result is discarded and no done is issued.
- States:
  - IDLE: busy=0, done=0.
    - If start=1: acc<=data_in, cnt<=shamt, fill<=arith & data_in[WIDTH-1], state<=SHIFT.
    - Else stay in IDLE.
  - SHIFT: busy=1.
    - If cnt!=0: acc<={fill, acc[WIDTH-1:1]}, cnt<=cnt-1, stay in SHIFT.
    - If cnt==0: data_out<=acc, state<=DONE.
  - DONE: busy=1, done=1 for exactly this one cycle, state<=IDLE unconditionally.
- start is ignored while busy=1, including in DONE. Issuing back-to-back operations therefore needs at least one IDLE cycle between them.
- Latency:
  - With start sampled at edge E0, SHIFT lasts shamt+1 cycles.
  - done is high during cycle shamt+2 after E0 and data_out is valid in that same cycle.
  - shamt=0 gives a 2-cycle latency with the result equal to data_in.
- Fill rule: the fill bit is latched once at accept, so the sign bit is replicated on every shift. A logical shift always fills with 0.
- Count rule: shamt >= WIDTH (possible only when 2**SHAMT_W > WIDTH) is clamped to WIDTH on accept. The result is then all-fill: all zeros for logical, all sign bits for arithmetic.
- Input stability: data_in, shamt and arith may change freely after the accept cycle; the block works only from its internal registers.
- data_out changes only on the SHIFT→DONE transition or on reset. It does not change on accept.
- done and busy are registered-state decodes. There is no combinational path from start to busy or done.

Test Plan:
1. After reset, check data_out=0, busy=0, done=0. Then apply start, data_in=0x80000000, shamt=4, arith=0 → busy rises the next cycle, done pulses 6 cycles after the start edge, data_out=0x08000000.
2. Apply the same operand and shamt with arith=1 → data_out=0xF8000000 at the done pulse. Then apply data_in=0x80000001, shamt=31: arith=1 → 0xFFFFFFFF after 33 cycles; arith=0 → 0x00000001.
3. Apply shamt=0, data_in=0x1234ABCD, arith=1 → done 2 cycles after start, data_out=0x1234ABCD, done width exactly 1 cycle.
4. Start with data_in=0x0000F000, shamt=8, arith=0, then pulse start with different operands while busy=1 and during DONE → second requests are ignored, data_out=0x000000F0, one done pulse only. A start issued in the following IDLE cycle is accepted.
5. Start with shamt=20, then assert rst for 1 cycle at the 5th SHIFT cycle → next cycle busy=0, done=0, data_out=0, and no done pulse follows. A new operation then completes normally.
6. Change data_in, shamt and arith every cycle after the accept of data_in=0xFF000000, shamt=8, arith=1 → result still 0xFFFF0000, and data_out keeps its previous value until the done cycle.
